// File: rtl/avc_arbiter_if.sv
// Bundle of the requester, AVC and policy-store signals around avc_arbiter.
// The master modport is the arbiter's own view; slave is the environment's view.
interface avc_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]      req;
  logic [15*NREQ-1:0]   req_id;
  logic [NREQ-1:0]      gnt;
  logic [NREQ-1:0]      done;
  logic [1:0]           rsp_perm;
  logic                 rsp_hit;
  logic                 rsp_err;
  logic                 avc_go;
  logic                 avc_wr;
  logic [14:0]          avc_id;
  logic [1:0]           avc_perm;
  logic                 avc_hit;
  logic                 avc_ready;
  logic [1:0]           avc_acc_perm;
  logic                 pol_req;
  logic [14:0]          pol_id;
  logic                 pol_ack;
  logic [1:0]           pol_perm;

  modport master (
    input  req, req_id, avc_hit, avc_ready, avc_acc_perm, pol_ack, pol_perm,
    output gnt, done, rsp_perm, rsp_hit, rsp_err,
           avc_go, avc_wr, avc_id, avc_perm, pol_req, pol_id
  );

  modport slave (
    output req, req_id, avc_hit, avc_ready, avc_acc_perm, pol_ack, pol_perm,
    input  gnt, done, rsp_perm, rsp_hit, rsp_err,
           avc_go, avc_wr, avc_id, avc_perm, pol_req, pol_id
  );
endinterface

// File: rtl/avc_arbiter.sv
// Round-robin arbiter sharing one AVC among NREQ requesters; misses are refilled
// from the policy store, with a bounded wait for the fetch acknowledge.
module avc_arbiter #(
  parameter int NREQ          = 4,
  parameter int FETCH_TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  avc_arbiter_if.master bus
);

  localparam int          PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [8:0]  TMO = 9'(FETCH_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WAIT_LK,
    S_FETCH,
    S_FILL,
    S_WAIT_FILL,
    S_RESP
  } state_t;

  state_t          r_state, w_state_next;
  logic            r_run_ok;
  logic [PW-1:0]   r_ptr, w_ptr_next;
  logic [NREQ-1:0] r_gnt, w_gnt_next;
  logic [14:0]     r_id, w_id_next;
  logic [1:0]      r_perm, w_perm_next;
  logic            r_hit, w_hit_next;
  logic            r_err, w_err_next;
  logic [8:0]      r_cnt, w_cnt_next;
  logic [1:0]      r_rsp_perm, w_rsp_perm_next;
  logic            r_rsp_hit, w_rsp_hit_next;
  logic            r_rsp_err, w_rsp_err_next;

  logic [14:0]     w_req_id [NREQ];
  logic            w_pick_vld;
  logic [PW-1:0]   w_pick;

  logic            w_avc_go;
  logic            w_avc_wr;
  logic [14:0]     w_avc_id;
  logic [1:0]      w_avc_perm;
  logic            w_pol_req;
  logic [14:0]     w_pol_id;
  logic [NREQ-1:0] w_done;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_id
      assign w_req_id[gi] = bus.req_id[15*gi +: 15];
    end
  endgenerate

  function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int off);
    int s;
    s = 32'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return s[PW-1:0];
  endfunction

  // Lowest offset from the pointer wins, so scan offsets high to low and overwrite.
  always_comb begin
    w_pick_vld = 1'b0;
    w_pick     = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req[wrap_idx(r_ptr, i)]) begin
        w_pick_vld = 1'b1;
        w_pick     = wrap_idx(r_ptr, i);
      end
    end
  end

  // Arbitration stays off until one clock edge has passed with reset released.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_run_ok <= 1'b0;
    else      r_run_ok <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next    = r_state;
    w_ptr_next      = r_ptr;
    w_gnt_next      = r_gnt;
    w_id_next       = r_id;
    w_perm_next     = r_perm;
    w_hit_next      = r_hit;
    w_err_next      = r_err;
    w_cnt_next      = r_cnt;
    w_rsp_perm_next = r_rsp_perm;
    w_rsp_hit_next  = r_rsp_hit;
    w_rsp_err_next  = r_rsp_err;
    w_avc_go        = 1'b0;
    w_avc_wr        = 1'b0;
    w_avc_id        = '0;
    w_avc_perm      = '0;
    w_pol_req       = 1'b0;
    w_pol_id        = '0;
    w_done          = '0;

    unique case (r_state)
      S_IDLE: begin
        if (r_run_ok && w_pick_vld) begin
          w_gnt_next         = '0;
          w_gnt_next[w_pick] = 1'b1;
          w_id_next          = w_req_id[w_pick];
          w_perm_next        = 2'b00;
          w_hit_next         = 1'b0;
          w_err_next         = 1'b0;
          w_ptr_next         = wrap_idx(w_pick, 1);
          w_state_next       = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        w_avc_go     = 1'b1;
        w_avc_id     = r_id;
        w_state_next = S_WAIT_LK;
      end
      S_WAIT_LK: begin
        if (bus.avc_ready) begin
          if (bus.avc_hit) begin
            w_perm_next  = bus.avc_acc_perm;
            w_hit_next   = 1'b1;
            w_state_next = S_RESP;
          end else begin
            w_cnt_next   = '0;
            w_state_next = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        w_pol_req = 1'b1;
        w_pol_id  = r_id;
        // An acknowledge in the final counted cycle still wins over the timeout.
        if (bus.pol_ack) begin
          w_perm_next  = bus.pol_perm;
          w_state_next = S_FILL;
        end else if (r_cnt == TMO) begin
          w_perm_next  = 2'b00;
          w_err_next   = 1'b1;
          w_state_next = S_RESP;
        end else begin
          w_cnt_next = r_cnt + 9'd1;
        end
      end
      S_FILL: begin
        w_avc_go     = 1'b1;
        w_avc_wr     = 1'b1;
        w_avc_id     = r_id;
        w_avc_perm   = r_perm;
        w_state_next = S_WAIT_FILL;
      end
      S_WAIT_FILL: begin
        if (bus.avc_ready) begin
          w_hit_next   = 1'b0;
          w_state_next = S_RESP;
        end
      end
      S_RESP: begin
        w_done       = r_gnt;
        w_gnt_next   = '0;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase

    // Response registers load on the way into RESP and then hold until the next one.
    if (w_state_next == S_RESP && r_state != S_RESP) begin
      w_rsp_perm_next = w_perm_next;
      w_rsp_hit_next  = w_hit_next;
      w_rsp_err_next  = w_err_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr      <= '0;
      r_gnt      <= '0;
      r_id       <= '0;
      r_perm     <= '0;
      r_hit      <= 1'b0;
      r_err      <= 1'b0;
      r_cnt      <= '0;
      r_rsp_perm <= '0;
      r_rsp_hit  <= 1'b0;
      r_rsp_err  <= 1'b0;
    end else begin
      r_ptr      <= w_ptr_next;
      r_gnt      <= w_gnt_next;
      r_id       <= w_id_next;
      r_perm     <= w_perm_next;
      r_hit      <= w_hit_next;
      r_err      <= w_err_next;
      r_cnt      <= w_cnt_next;
      r_rsp_perm <= w_rsp_perm_next;
      r_rsp_hit  <= w_rsp_hit_next;
      r_rsp_err  <= w_rsp_err_next;
    end
  end

  assign bus.gnt      = r_gnt;
  assign bus.done     = w_done;
  assign bus.rsp_perm = r_rsp_perm;
  assign bus.rsp_hit  = r_rsp_hit;
  assign bus.rsp_err  = r_rsp_err;
  assign bus.avc_go   = w_avc_go;
  assign bus.avc_wr   = w_avc_wr;
  assign bus.avc_id   = w_avc_id;
  assign bus.avc_perm = w_avc_perm;
  assign bus.pol_req  = w_pol_req;
  assign bus.pol_id   = w_pol_id;

endmodule
